// File: rtl/ascon_encrypt_ctrl.sv
// ascon_encrypt_ctrl: round-by-round sequencer for the ASCON-128 encryption datapath
module ascon_encrypt_ctrl #(
  parameter int ROUNDS_A = 12,
  parameter int ROUNDS_B = 6,
  parameter int RC_W = 4
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            start,
  input  logic            ad_empty,
  input  logic            ad_valid,
  input  logic            ad_last,
  input  logic            pt_valid,
  input  logic            pt_last,
  output logic            ad_ready,
  output logic            pt_ready,
  output logic            load_iv,
  output logic            perm_en,
  output logic [RC_W-1:0] rc_idx,
  output logic            xor_key_init,
  output logic            absorb_ad,
  output logic            absorb_pt,
  output logic            dom_sep,
  output logic            xor_key_fin,
  output logic            ct_valid,
  output logic            tag_valid,
  output logic            busy
);
  localparam logic [3:0] IDLE     = 4'd0;
  localparam logic [3:0] LOAD     = 4'd1;
  localparam logic [3:0] INIT     = 4'd2;
  localparam logic [3:0] KEY1     = 4'd3;
  localparam logic [3:0] AD_WAIT  = 4'd4;
  localparam logic [3:0] AD_PERM  = 4'd5;
  localparam logic [3:0] DSEP     = 4'd6;
  localparam logic [3:0] PT_WAIT  = 4'd7;
  localparam logic [3:0] PT_PERM  = 4'd8;
  localparam logic [3:0] FIN_KEY  = 4'd9;
  localparam logic [3:0] FIN_PERM = 4'd10;
  localparam logic [3:0] TAG      = 4'd11;
  localparam logic [RC_W-1:0] RC_LAST = RC_W'(ROUNDS_A - 1);
  localparam logic [RC_W-1:0] RC_PB0  = RC_W'(ROUNDS_A - ROUNDS_B);
  logic [3:0]      state;
  logic [RC_W-1:0] cnt;
  logic            ad_empty_r;
  logic            ad_last_r;
  logic            last;
  logic [RC_W-1:0] cnt_nx;
  assign last = cnt == RC_LAST;
  assign cnt_nx = last ? '0 : cnt + RC_W'(1);
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      cnt <= '0;
      ad_empty_r <= 1'b0;
      ad_last_r <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          state <= LOAD;
          ad_empty_r <= ad_empty;
        end
        LOAD: begin
          state <= INIT;
          cnt <= '0;
        end
        INIT: begin
          cnt <= cnt_nx;
          if (last) state <= KEY1;
        end
        KEY1: state <= ad_empty_r ? DSEP : AD_WAIT;
        AD_WAIT: if (ad_valid) begin
          state <= AD_PERM;
          cnt <= RC_PB0;
          ad_last_r <= ad_last;
        end
        AD_PERM: begin
          cnt <= cnt_nx;
          if (last) state <= ad_last_r ? DSEP : AD_WAIT;
        end
        DSEP: state <= PT_WAIT;
        PT_WAIT: if (pt_valid) begin
          state <= pt_last ? FIN_KEY : PT_PERM;
          cnt <= pt_last ? '0 : RC_PB0;
        end
        PT_PERM: begin
          cnt <= cnt_nx;
          if (last) state <= PT_WAIT;
        end
        FIN_KEY: begin
          state <= FIN_PERM;
          cnt <= '0;
        end
        FIN_PERM: begin
          cnt <= cnt_nx;
          if (last) state <= TAG;
        end
        TAG: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
  always_comb begin
    busy = state != IDLE;
    load_iv = state == LOAD;
    perm_en = state == INIT || state == AD_PERM || state == PT_PERM || state == FIN_PERM;
    rc_idx = perm_en ? cnt : '0;
    xor_key_init = state == KEY1;
    ad_ready = state == AD_WAIT;
    absorb_ad = ad_ready && ad_valid;
    dom_sep = state == DSEP;
    pt_ready = state == PT_WAIT;
    absorb_pt = pt_ready && pt_valid;
    ct_valid = absorb_pt;
    xor_key_fin = state == FIN_KEY;
    tag_valid = state == TAG;
  end
endmodule

// File: tb/tb_ascon_encrypt_ctrl.sv
// tb_ascon_encrypt_ctrl: directed table-driven check of the ASCON encryption sequencer
module tb_ascon_encrypt_ctrl;
  logic CLK, RST, start, ad_empty, ad_valid, ad_last, pt_valid, pt_last;
  logic ad_ready, pt_ready, load_iv, perm_en, xor_key_init, absorb_ad, absorb_pt;
  logic dom_sep, xor_key_fin, ct_valid, tag_valid, busy;
  logic [3:0] rc_idx;
  logic [15:0] outv;
  int n_chk, n_fail;
  localparam logic [15:0] BUSY = 16'h8000, TAG = 16'h4000, CT = 16'h2000, KF = 16'h1000;
  localparam logic [15:0] DS = 16'h0800, AP = 16'h0400, AA = 16'h0200, KI = 16'h0100;
  localparam logic [15:0] PE = 16'h0080, LD = 16'h0040, PR = 16'h0020, AR = 16'h0010;
  localparam int NV = 25;
  typedef struct {
    int sc;
    int cyc;
    logic [15:0] exp;
  } vec_t;
  vec_t tv[NV];
  ascon_encrypt_ctrl dut (
    .CLK(CLK), .RST(RST), .start(start), .ad_empty(ad_empty),
    .ad_valid(ad_valid), .ad_last(ad_last), .pt_valid(pt_valid), .pt_last(pt_last),
    .ad_ready(ad_ready), .pt_ready(pt_ready), .load_iv(load_iv), .perm_en(perm_en),
    .rc_idx(rc_idx), .xor_key_init(xor_key_init), .absorb_ad(absorb_ad),
    .absorb_pt(absorb_pt), .dom_sep(dom_sep), .xor_key_fin(xor_key_fin),
    .ct_valid(ct_valid), .tag_valid(tag_valid), .busy(busy)
  );
  assign outv = {busy, tag_valid, ct_valid, xor_key_fin, dom_sep, absorb_pt, absorb_ad,
                 xor_key_init, perm_en, load_iv, pt_ready, ad_ready, rc_idx};
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask
  task automatic run_table(input int sc);
    int tags, adr;
    tags = 0;
    adr = 0;
    ad_empty = sc == 1;
    ad_valid = 1'b1;
    ad_last = 1'b1;
    pt_valid = 1'b1;
    pt_last = 1'b1;
    start = 1'b1;
    for (int c = 0; c <= 40; c++) begin
      #1;
      for (int i = 0; i < NV; i++)
        if (tv[i].sc == sc && tv[i].cyc == c)
          chk($sformatf("sc%0d_c%0d", sc, c), {16'h0, outv}, {16'h0, tv[i].exp});
      if (tag_valid) tags++;
      if (ad_ready) adr++;
      tick();
      start = 1'b0;
    end
    chk($sformatf("sc%0d_tag_count", sc), tags, 1);
    if (sc == 1) chk("sc1_ad_ready_never", adr, 0);
  endtask
  initial begin
    int ad_n, ct_n, stall, tag_c, tag_n, fin_seen, rc_first, ct_c, ld_n, bad;
    int pc[3];
    n_chk = 0;
    n_fail = 0;
    tv = '{
      '{0, 0, 16'h0}, '{0, 1, BUSY | LD}, '{0, 2, BUSY | PE}, '{0, 7, BUSY | PE | 16'd5},
      '{0, 13, BUSY | PE | 16'd11}, '{0, 14, BUSY | KI}, '{0, 15, BUSY | AR | AA},
      '{0, 16, BUSY | PE | 16'd6}, '{0, 21, BUSY | PE | 16'd11}, '{0, 22, BUSY | DS},
      '{0, 23, BUSY | PR | AP | CT}, '{0, 24, BUSY | KF}, '{0, 25, BUSY | PE},
      '{0, 36, BUSY | PE | 16'd11}, '{0, 37, BUSY | TAG}, '{0, 38, 16'h0},
      '{1, 1, BUSY | LD}, '{1, 14, BUSY | KI}, '{1, 15, BUSY | DS},
      '{1, 16, BUSY | PR | AP | CT}, '{1, 17, BUSY | KF}, '{1, 18, BUSY | PE},
      '{1, 29, BUSY | PE | 16'd11}, '{1, 30, BUSY | TAG}, '{1, 31, 16'h0}
    };
    RST = 1'b1;
    start = 1'b0;
    ad_empty = 1'b0;
    ad_valid = 1'b1;
    ad_last = 1'b0;
    pt_valid = 1'b1;
    pt_last = 1'b0;
    repeat (3) tick();
    #1;
    chk("reset_outputs", {16'h0, outv}, 32'h0);
    RST = 1'b0;
    tick();
    run_table(0);
    run_table(1);
    // 3 AD blocks (5-cycle stall before block 2) and 2 PT blocks
    ad_n = 0; ct_n = 0; stall = 0; tag_c = -1; fin_seen = 0; rc_first = -1;
    pc = '{0, 0, 0};
    ad_empty = 1'b0;
    pt_valid = 1'b1;
    start = 1'b1;
    for (int c = 0; c < 120; c++) begin
      ad_valid = !(ad_n == 1 && ad_ready && stall < 5);
      if (ad_n == 1 && ad_ready && stall < 5) stall++;
      ad_last = ad_n == 2;
      pt_last = ct_n == 1;
      #1;
      if (perm_en && !fin_seen && ct_n < 3) pc[ct_n]++;
      if (perm_en && ct_n == 1 && !fin_seen && rc_first < 0) rc_first = int'(rc_idx);
      if (xor_key_fin) fin_seen = 1;
      if (absorb_ad) ad_n++;
      if (ct_valid) ct_n++;
      if (tag_valid) tag_c = c;
      tick();
      start = 1'b0;
    end
    chk("multi_absorb_ad", ad_n, 3);
    chk("multi_ct_valid", ct_n, 2);
    chk("multi_tag_cycle", tag_c, 63);
    chk("multi_pb_after_pt1", pc[1], 6);
    chk("multi_pb_after_pt2", pc[2], 0);
    chk("multi_pb_first_rc", rc_first, 6);
    // pt_valid held through AD phase, start re-pulsed mid-message
    ct_c = -1; tag_c = -1; tag_n = 0; ld_n = 0; bad = 0;
    ad_last = 1'b1;
    pt_valid = 1'b1;
    pt_last = 1'b1;
    for (int c = 0; c < 60; c++) begin
      ad_valid = c >= 20;
      start = c == 0 || c == 10 || c == 18;
      #1;
      if (absorb_pt && !pt_ready) bad++;
      if (ct_valid && ct_c < 0) ct_c = c;
      if (load_iv) ld_n++;
      if (tag_valid) begin
        tag_c = c;
        tag_n++;
      end
      tick();
    end
    start = 1'b0;
    chk("ignore_first_ct", ct_c, 28);
    chk("ignore_tag_cycle", tag_c, 42);
    chk("ignore_tag_count", tag_n, 1);
    chk("ignore_restart", ld_n, 1);
    chk("ignore_pt_outside_wait", bad, 0);
    // reset during FIN_PERM
    ad_empty = 1'b0;
    ad_valid = 1'b1;
    pt_valid = 1'b1;
    start = 1'b1;
    for (int c = 0; c < 30; c++) begin
      tick();
      start = 1'b0;
    end
    #1;
    chk("pre_rst_fin_perm", {16'h0, outv}, {16'h0, BUSY | PE | 16'd5});
    RST = 1'b1;
    tick();
    RST = 1'b0;
    #1;
    chk("rst_mid_outputs", {16'h0, outv}, 32'h0);
    tag_n = 0;
    for (int c = 0; c < 20; c++) begin
      if (tag_valid) tag_n++;
      tick();
    end
    chk("rst_no_tag", tag_n, 0);
    run_table(0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
